puf_challenge_sequencer: RTL

- Sequences one PUF enrollment/authentication run over the scrambler LFSR.
- Loads a seed challenge into the scrambler, then for each of NUM_CHALLENGES steps: waits for the challenge to settle, triggers one ring-oscillator measurement, collects the response bit, and advances the scrambler.
- Delivers the assembled response word over a valid/ready handshake.
- Sits between the host/UART command logic and the scrambler + RO-compare datapath.

---
 rtl/puf_seq_pkg.sv | 22 ++
 rtl/puf_challenge_sequencer_if.sv | 12 +
 rtl/puf_seq_watchdog.sv | 34 +++
 rtl/puf_challenge_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/puf_seq_pkg.sv
// Shared types and helpers for the PUF challenge sequencer.
// Used by puf_challenge_sequencer and its optional watchdog.
package puf_seq_pkg;

    localparam int DEF_CHAL_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        MEASURE,
        WAIT,
        STEP,
        OUTPUT
    } seq_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/puf_challenge_sequencer_if.sv
// Response-word valid/ready channel from the sequencer to its consumer.
// The sequencer is the master; the host/UART side is the slave.
interface puf_resp_if #(
    parameter int NUM_CHALLENGES = 16
);
    logic                      resp_valid;
    logic                      resp_ready;
    logic [NUM_CHALLENGES-1:0] resp_data;

    modport master (output resp_valid, output resp_data, input resp_ready);
    modport slave  (input resp_valid, input resp_data, output resp_ready);
endinterface

// File: rtl/puf_seq_watchdog.sv
// WAIT-state watchdog: cleared by load, counts while count is high, and
// flags expired on the cycle the count reaches LIMIT-1.
module puf_seq_watchdog
    import puf_seq_pkg::*;
#(
    parameter int LIMIT = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic count,
    output logic expired
);
    localparam int           W    = cnt_width(LIMIT);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (count && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expired = count && (cnt_q == LAST);
endmodule

// File: rtl/puf_challenge_sequencer.sv
// Sequences one PUF run: seed load, settle, measure, collect, advance, deliver.
// Define PUF_SEQ_TIMEOUT_EN to add the WAIT watchdog and the timeout_err port.
module puf_challenge_sequencer
    import puf_seq_pkg::*;
#(
    parameter int CHAL_W         = DEF_CHAL_W,
    parameter int NUM_CHALLENGES = 16,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [CHAL_W-1:0] seed,
    output logic              busy,
    output logic [CHAL_W-1:0] chal_seed,
    output logic              scr_load,
    output logic              scr_increment,
    input  logic [CHAL_W-1:0] scr_challenge,
    output logic [CHAL_W-1:0] last_challenge,
    output logic              meas_start,
    input  logic              meas_done,
    input  logic              meas_bit,
    puf_resp_if.master        resp
`ifdef PUF_SEQ_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);
    localparam int                IDX_W       = cnt_width(NUM_CHALLENGES);
    localparam int                SET_W       = cnt_width(SETTLE_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(NUM_CHALLENGES - 1);
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

    if (NUM_CHALLENGES < 1 || NUM_CHALLENGES > 64 || SETTLE_CYCLES < 1 ||
        SETTLE_CYCLES > 255 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("puf_challenge_sequencer: parameter out of range");
    end

    seq_state_t                state_q, state_d;
    logic [SET_W-1:0]          settle_cnt_q, settle_cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      busy_q, busy_d;
    logic [CHAL_W-1:0]         chal_seed_q, chal_seed_d;
    logic                      scr_load_q, scr_load_d;
    logic                      scr_inc_q, scr_inc_d;
    logic [CHAL_W-1:0]         last_chal_q, last_chal_d;
    logic                      meas_start_q, meas_start_d;
    logic                      resp_valid_q, resp_valid_d;
    logic [NUM_CHALLENGES-1:0] resp_data_q, resp_data_d;

`ifdef PUF_SEQ_TIMEOUT_EN
    logic timeout_err_q, timeout_err_d;
    logic wd_expired;

    // MEASURE always leads into WAIT, so clearing there restarts the count on WAIT entry.
    puf_seq_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .load    (state_q == MEASURE),
        .count   (state_q == WAIT),
        .expired (wd_expired)
    );
`endif

    // Pulse outputs are decoded from the transition into their state so that
    // the registered copy is high for exactly the one cycle spent there.
    always_comb begin
        state_d       = state_q;
        settle_cnt_d  = settle_cnt_q;
        idx_d         = idx_q;
        chal_seed_d   = chal_seed_q;
        last_chal_d   = last_chal_q;
        resp_data_d   = resp_data_q;
        scr_load_d    = 1'b0;
        scr_inc_d     = 1'b0;
        meas_start_d  = 1'b0;
        resp_valid_d  = 1'b0;
`ifdef PUF_SEQ_TIMEOUT_EN
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    chal_seed_d   = seed;
                    resp_data_d   = '0;
                    idx_d         = '0;
                    scr_load_d    = 1'b1;
                    state_d       = LOAD;
`ifdef PUF_SEQ_TIMEOUT_EN
                    timeout_err_d = 1'b0;
`endif
                end
            end
            LOAD, STEP: begin
                settle_cnt_d = '0;
                state_d      = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    meas_start_d = 1'b1;
                    last_chal_d  = scr_challenge;
                    state_d      = MEASURE;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            MEASURE: state_d = WAIT;
            WAIT: begin
                // meas_done is checked first so it wins over an expiring watchdog.
                if (meas_done) begin
                    resp_data_d[idx_q] = meas_bit;
                    if (idx_q == IDX_LAST) begin
                        resp_valid_d = 1'b1;
                        state_d      = OUTPUT;
                    end else begin
                        idx_d     = idx_q + 1'b1;
                        scr_inc_d = 1'b1;
                        state_d   = STEP;
                    end
                end
`ifdef PUF_SEQ_TIMEOUT_EN
                else if (wd_expired) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end
`endif
            end
            OUTPUT: begin
                if (resp.resp_ready) state_d = IDLE;
                else                 resp_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // NOTE: every flop here is plain state (no memory arrays), so all of it is
    // cleared by the asynchronous reset and a mid-run reset drops the partial word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            settle_cnt_q  <= '0;
            idx_q         <= '0;
            busy_q        <= 1'b0;
            chal_seed_q   <= '0;
            scr_load_q    <= 1'b0;
            scr_inc_q     <= 1'b0;
            last_chal_q   <= '0;
            meas_start_q  <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_data_q   <= '0;
`ifdef PUF_SEQ_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            settle_cnt_q  <= settle_cnt_d;
            idx_q         <= idx_d;
            busy_q        <= busy_d;
            chal_seed_q   <= chal_seed_d;
            scr_load_q    <= scr_load_d;
            scr_inc_q     <= scr_inc_d;
            last_chal_q   <= last_chal_d;
            meas_start_q  <= meas_start_d;
            resp_valid_q  <= resp_valid_d;
            resp_data_q   <= resp_data_d;
`ifdef PUF_SEQ_TIMEOUT_EN
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign busy            = busy_q;
    assign chal_seed       = chal_seed_q;
    assign scr_load        = scr_load_q;
    assign scr_increment   = scr_inc_q;
    assign last_challenge  = last_chal_q;
    assign meas_start      = meas_start_q;
    assign resp.resp_valid = resp_valid_q;
    assign resp.resp_data  = resp_data_q;
`ifdef PUF_SEQ_TIMEOUT_EN
    assign timeout_err     = timeout_err_q;
`endif
endmodule
